opacc_ctrl: RTL and testbench
=============================

# opacc_ctrl

Sequencer for the matrix unit's outer-product accumulator (opacc). It accepts one tile command at a time and then runs the tile through three phases: load C rows, apply K rank-1 updates (C += A·Bᵀ), and drain C rows. It drives opacc's `en_c`/`en_ab` strobes and the zero-select on `vi_c`. It sits between the vector issue logic (command plus A/B/C operand streams) and opacc, and replaces the free-running shift FSM.

## Interface
- `ML`, 2: number of C rows (MLEN/XLEN); one `en_c` pulse shifts exactly one row.
- `KW`, 16: width of the rank-1 update count.
- `clk`  in  1  clock; all logic is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  tile command is present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_load_c`  in  1  1: load C rows from `c_in`; 0: start from zero.
- `cmd_k`  in  KW  number of A/B beats to accumulate; 0 is legal.
- `c_in_valid` / `c_in_ready`  in / out  1  C-row input handshake.
- `ab_valid` / `ab_ready`  in / out  1  A/B operand beat handshake.
- `c_out_valid` / `c_out_ready`  out / in  1  C-row output handshake; the data is opacc `vo_c`.
- `c_out_last`  out  1  marks the final drained row.
- `en_c`  out  1  opacc row shift/load strobe.
- `en_ab`  out  1  opacc accumulate strobe.
- `c_zero`  out  1  selects zero onto opacc `vi_c`.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when a tile finishes.

## Operation
- **States:** FLUSH, IDLE, LOAD, ACC, DRAIN.
- **Counters:**
  - `row_cnt`, $clog2(ML+1) bits.
  - `k_cnt`, KW bits, loaded from `cmd_k`.
  - Latched `load_c` flag.
- **FLUSH** (entered on reset):
  - `en_c=1`, `c_zero=1` for exactly ML cycles, which zeroes opacc; then go to IDLE.
  - No handshake is ready during FLUSH.
- **IDLE:**
  - `cmd_ready=1`.
  - On `cmd_valid`, latch `cmd_k` and `cmd_load_c`, and clear `row_cnt`.
  - Next state is LOAD if `cmd_load_c=1`; else ACC if `cmd_k!=0`; else DRAIN.
- **LOAD:**
  - `c_in_ready=1`; `en_c = c_in_valid`; `c_zero=0`.
  - Each fire increments `row_cnt`.
  - After the ML-th fire: go to ACC if k≠0, else DRAIN.
- **ACC:**
  - `ab_ready=1`; `en_ab = ab_valid`.
  - Each fire decrements `k_cnt`.
  - The fire that takes `k_cnt` from 1 to 0 moves to DRAIN.
- **DRAIN:**
  - `c_out_valid=1`; `en_c = c_out_ready`; `c_zero=1`.
  - Draining with zeros shifted in leaves opacc zeroed, so a following `cmd_load_c=0` tile starts from C=0.
  - `c_out_last=1` when `row_cnt==ML-1`.
  - The ML-th fire asserts `done` and returns to IDLE.
- **Exclusivity:**
  - `en_c` and `en_ab` are never high in the same cycle.
  - Any ready or valid output outside its own state is 0.
- **Counters are exact:** no wrap is permitted. `row_cnt` saturates logically at ML because the FSM exits on that fire.
- **Combinational outputs:** all outputs are functions of state and inputs.
  - `en_c`, `en_ab`, `c_in_ready`, `ab_ready`, `c_out_valid` are combinational.
  - `done` is registered.

## Timing
- **Reset values** (while `reset_n` is low): state=FLUSH, counters=0.
  - Every output is 0 except: `en_c=1`, `c_zero=1`, `busy=1`.
- **FLUSH length:** exactly ML cycles after reset deassertion. `cmd_ready` first rises in cycle ML+1.
- **Minimum tile latency**, measured from the cycle of the `cmd_valid & cmd_ready` fire to the `done` pulse, with all streams always valid/ready:
  - 1 + ML·load_c + K + ML cycles.
  - `done` is asserted on the cycle after the last DRAIN fire; it coincides with `cmd_ready=1`.
- **Back-pressure:**
  - A deasserted valid or ready stalls the current phase indefinitely. No strobe is issued and counters hold.
  - A command arriving while not in IDLE is ignored because `cmd_ready=0`; it stays pending.
- **Reset mid-operation:** abandon the tile immediately and re-enter FLUSH. Partial C contents are cleared by the flush; no `done` is issued.

## Configuration
- **`OPACC_CTRL_PERF_EN` defined:** adds two 32-bit outputs, `perf_busy_cycles` and `perf_stall_cycles`.
  - `perf_busy_cycles` counts cycles in LOAD/ACC/DRAIN.
  - `perf_stall_cycles` counts cycles in LOAD/ACC/DRAIN where the active handshake does not fire.
  - Both are reset to 0 and wrap modulo 2³².
- **`OPACC_CTRL_PERF_EN` undefined:** these ports and counters do not exist. All other behaviour is identical.

## Test plan
- **Reset/flush:** with ML=2, release `reset_n`.
  - `en_c=1`, `c_zero=1` for exactly 2 cycles; `cmd_ready=1` on cycle 3; opacc `reg_c` is all zero.
- **Full tile:** command `cmd_load_c=1`, `cmd_k=3`, all streams always valid/ready.
  - `en_c` for 2 cycles, `en_ab` for 3, then 2 drain beats with `c_out_last` on the second; `done` 8 cycles after the command fire.
  - The drained rows equal the loaded C plus Σ A·Bᵀ.
- **Zero-start with no updates:** `cmd_load_c=0`, `cmd_k=0`.
  - LOAD and ACC are skipped; 2 drain beats of zeros; `done` 3 cycles after the command fire.
- **Back-pressure:** hold `ab_valid=0` for 4 cycles mid-ACC, and `c_out_ready=0` for 3 cycles mid-DRAIN.
  - No strobes while stalled; the count is unchanged; the result matches the unstalled run.
  - With `OPACC_CTRL_PERF_EN` defined, `perf_stall_cycles=7`.
- **Reset mid-ACC:** assert `reset_n=0` after 1 of 3 A/B beats.
  - FLUSH reruns and no `done` is issued; the next `cmd_load_c=0`, `cmd_k=0` tile drains all zeros.
- **Back-to-back commands:** keep `cmd_valid` high across two tiles.
  - The second command fires in the same cycle as the first tile's `done`.

Source files
------------

// File: rtl/opacc_ctrl.sv
// Tile sequencer for opacc: FLUSH zeroes C, then each command runs LOAD (optional) -> ACC (K beats) -> DRAIN.
// Latency 1 + ML*load_c + K + ML cycles from command fire to done; any stalled valid/ready holds the phase with no strobe.
// Optional OPACC_CTRL_PERF_EN adds busy/stall cycle counters.
module opacc_ctrl #(
    parameter int ML = 2,
    parameter int KW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_load_c,
    input  logic [KW-1:0] cmd_k,
    input  logic          c_in_valid,
    output logic          c_in_ready,
    input  logic          ab_valid,
    output logic          ab_ready,
    output logic          c_out_valid,
    input  logic          c_out_ready,
    output logic          c_out_last,
    output logic          en_c,
    output logic          en_ab,
    output logic          c_zero,
    output logic          busy,
    output logic          done
`ifdef OPACC_CTRL_PERF_EN
    ,
    output logic [31:0]   perf_busy_cycles,
    output logic [31:0]   perf_stall_cycles
`endif
);

    localparam int RW = $clog2(ML + 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ML - 1);

    typedef enum logic [2:0] {
        FLUSH,
        IDLE,
        LOAD,
        ACC,
        DRAIN
    } state_t;

    state_t        state;
    logic [RW-1:0] row_cnt;
    logic [KW-1:0] k_cnt;
    logic          row_last;

    always_comb begin
        row_last    = (row_cnt == ROW_LAST);
        cmd_ready   = (state == IDLE);
        c_in_ready  = (state == LOAD);
        ab_ready    = (state == ACC);
        c_out_valid = (state == DRAIN);
        c_out_last  = (state == DRAIN) && row_last;
        en_c        = (state == FLUSH)
                    || ((state == LOAD) && c_in_valid)
                    || ((state == DRAIN) && c_out_ready);
        en_ab       = (state == ACC) && ab_valid;
        // Draining shifts zeros in, so opacc is left clean for a zero-start tile.
        c_zero      = (state == FLUSH) || (state == DRAIN);
        busy        = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= FLUSH;
            row_cnt <= '0;
            k_cnt   <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                FLUSH: begin
                    if (row_last) begin
                        row_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        row_cnt <= row_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (cmd_valid) begin
                        k_cnt   <= cmd_k;
                        row_cnt <= '0;
                        if (cmd_load_c)
                            state <= LOAD;
                        else if (cmd_k != '0)
                            state <= ACC;
                        else
                            state <= DRAIN;
                    end
                end
                LOAD: begin
                    if (c_in_valid) begin
                        if (row_last) begin
                            row_cnt <= '0;
                            state   <= (k_cnt != '0) ? ACC : DRAIN;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (ab_valid) begin
                        k_cnt <= k_cnt - 1'b1;
                        if (k_cnt == KW'(1))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (c_out_ready) begin
                        if (row_last) begin
                            row_cnt <= '0;
                            done    <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                default: state <= FLUSH;
            endcase
        end
    end

`ifdef OPACC_CTRL_PERF_EN
    logic active;
    logic stalled;

    always_comb begin
        active  = (state == LOAD) || (state == ACC) || (state == DRAIN);
        stalled = ((state == LOAD) && !c_in_valid)
               || ((state == ACC) && !ab_valid)
               || ((state == DRAIN) && !c_out_ready);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (active)
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            if (stalled)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_opacc_ctrl.sv
// Bench for opacc_ctrl: a small opacc data stand-in plus a handshake-sequence model built per command.
module tb_opacc_ctrl;
    localparam int ML = 2;
    localparam int KW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_load_c = 1'b0;
    logic [KW-1:0] cmd_k = '0;
    logic          c_in_valid = 1'b0, c_in_ready;
    logic          ab_valid = 1'b0, ab_ready;
    logic          c_out_valid, c_out_ready = 1'b0, c_out_last;
    logic          en_c, en_ab, c_zero, busy, done;
`ifdef OPACC_CTRL_PERF_EN
    logic [31:0]   perf_busy_cycles, perf_stall_cycles;
`endif

    always #5 clk = ~clk;

    opacc_ctrl #(.ML(ML), .KW(KW)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load_c(cmd_load_c), .cmd_k(cmd_k),
        .c_in_valid(c_in_valid), .c_in_ready(c_in_ready),
        .ab_valid(ab_valid), .ab_ready(ab_ready),
        .c_out_valid(c_out_valid), .c_out_ready(c_out_ready), .c_out_last(c_out_last),
        .en_c(en_c), .en_ab(en_ab), .c_zero(c_zero), .busy(busy), .done(done)
`ifdef OPACC_CTRL_PERF_EN
        , .perf_busy_cycles(perf_busy_cycles), .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    // Stand-in for opacc: row shift on en_c, per-row rank-1 accumulate on en_ab.
    int reg_c [ML];
    int c_in_dat;
    int a_dat [ML];
    int b_dat;
    bit poison = 1'b0;
    int vo_c;

    always @(posedge clk) begin
        if (poison) begin
            for (int i = 0; i < ML; i++) reg_c[i] <= 99;
        end else if (en_c) begin
            reg_c[0] <= c_zero ? 0 : c_in_dat;
            for (int i = 1; i < ML; i++) reg_c[i] <= reg_c[i-1];
        end else if (en_ab) begin
            for (int i = 0; i < ML; i++) reg_c[ML-1-i] <= reg_c[ML-1-i] + a_dat[i] * b_dat;
        end
    end
    always_comb vo_c = reg_c[ML-1];

    int n_checks = 0;
    int n_err = 0;

    // Expected handshake sequence of the current tile: 1=load beat, 2=A/B beat, 3=drain beat.
    int exp_q [$];
    int c_vals [ML];
    int a_vals [16][ML];
    int b_vals [16];
    int exp_rows [ML];
    int nl, na, nd;
    int ab_stall_left, d_stall_left;
    bit done_exp = 1'b0;
    bit fire_with_done;
    int cyc = 0, t_fire = 0, lat = 0;
    int tiles_done, ncmd = 0, nissued = 0, mode = 0;
    bit q_lc [2];
    int q_k [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        int ai;
        if (nissued < ncmd) begin
            cmd_valid  = 1'b1;
            cmd_load_c = q_lc[nissued];
            cmd_k      = KW'(q_k[nissued]);
        end else begin
            cmd_valid = 1'b0;
        end
        case (mode)
            1: begin
                c_in_valid  = ($urandom_range(0, 3) != 0);
                ab_valid    = ($urandom_range(0, 3) != 0);
                c_out_ready = ($urandom_range(0, 3) != 0);
            end
            2: begin
                c_in_valid  = 1'b1;
                ab_valid    = !(na == 1 && ab_stall_left > 0);
                c_out_ready = !(nd == 1 && d_stall_left > 0);
            end
            default: begin
                c_in_valid  = 1'b1;
                ab_valid    = 1'b1;
                c_out_ready = 1'b1;
            end
        endcase
        c_in_dat = (nl < ML) ? c_vals[nl] : 0;
        ai = (na < 16) ? na : 15;
        for (int j = 0; j < ML; j++) a_dat[j] = a_vals[ai][j];
        b_dat = b_vals[ai];
    endtask

    task automatic monitor();
        int ph;
        bit lf, af, df;
        int lc, k;
        ph = (exp_q.size() > 0) ? exp_q[0] : 0;
        cyc++;
        chk("done", done, done_exp);
        if (done) begin
            tiles_done++;
            lat = cyc - t_fire;
        end
        chk("cmd_ready", cmd_ready, ph == 0);
        chk("busy", busy, ph != 0);
        chk("c_in_ready", c_in_ready, ph == 1);
        chk("ab_ready", ab_ready, ph == 2);
        chk("c_out_valid", c_out_valid, ph == 3);
        chk("en_c", en_c, (ph == 1 && c_in_valid) || (ph == 3 && c_out_ready));
        chk("en_ab", en_ab, ph == 2 && ab_valid);
        if (ph == 1 || ph == 3) chk("c_zero", c_zero, ph == 3);
        chk("c_out_last", c_out_last, ph == 3 && exp_q.size() == 1);
        lf = c_in_ready && c_in_valid;
        af = ab_ready && ab_valid;
        df = c_out_valid && c_out_ready;
        done_exp = 1'b0;
        if (ph == 2 && !ab_valid) ab_stall_left--;
        if (ph == 3 && !c_out_ready) d_stall_left--;
        if ((ph == 1 && lf) || (ph == 2 && af) || (ph == 3 && df)) begin
            void'(exp_q.pop_front());
            if (lf) nl++;
            if (af) na++;
            if (df) begin
                chk("vo_c", vo_c, exp_rows[nd]);
                nd++;
                if (exp_q.size() == 0) done_exp = 1'b1;
            end
        end
        if (cmd_valid && cmd_ready) begin
            fire_with_done = done;
            t_fire = cyc;
            nissued++;
            lc = int'(cmd_load_c);
            k  = int'(cmd_k);
            for (int j = 0; j < ML; j++) c_vals[j] = $urandom_range(0, 999);
            for (int b = 0; b < 16; b++) begin
                b_vals[b] = $urandom_range(0, 9);
                for (int j = 0; j < ML; j++) a_vals[b][j] = $urandom_range(0, 9);
            end
            for (int j = 0; j < ML; j++) begin
                exp_rows[j] = lc ? c_vals[j] : 0;
                for (int b = 0; b < k; b++) exp_rows[j] += a_vals[b][j] * b_vals[b];
            end
            for (int i = 0; i < ML * lc; i++) exp_q.push_back(1);
            for (int i = 0; i < k; i++) exp_q.push_back(2);
            for (int i = 0; i < ML; i++) exp_q.push_back(3);
            nl = 0; na = 0; nd = 0;
            ab_stall_left = 4;
            d_stall_left = 3;
        end
    endtask

    task automatic step();
        @(negedge clk);
        drive();
        #1;
        monitor();
    endtask

    task automatic run_tiles(input int n, input bit lc0, input int k0, input bit lc1, input int k1,
                             input int md, input int abort_a, output int lat_o);
        bit aborted;
        aborted = 1'b0;
        q_lc[0] = lc0; q_k[0] = k0;
        q_lc[1] = lc1; q_k[1] = k1;
        ncmd = n; nissued = 0; tiles_done = 0; mode = md;
        for (int t = 0; t < 3000; t++) begin
            step();
            if (abort_a > 0 && nissued > 0 && na >= abort_a) begin
                aborted = 1'b1;
                break;
            end
            if (tiles_done == n) break;
        end
        if (!aborted) chk("tiles_completed", tiles_done, n);
        lat_o = lat;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_en_c"}, en_c, 1);
        chk({tag, "_c_zero"}, c_zero, 1);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_c_in_ready"}, c_in_ready, 0);
        chk({tag, "_ab_ready"}, ab_ready, 0);
        chk({tag, "_c_out_valid"}, c_out_valid, 0);
        chk({tag, "_c_out_last"}, c_out_last, 0);
        chk({tag, "_en_ab"}, en_ab, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        cmd_valid = 1'b0; ncmd = 0; nissued = 0;
        c_in_valid = 1'b1; ab_valid = 1'b1; c_out_ready = 1'b1;
        exp_q.delete();
        done_exp = 1'b0;
        #1;
        chk_reset_outputs("rst");
`ifdef OPACC_CTRL_PERF_EN
        chk("rst_perf_busy", perf_busy_cycles, 0);
        chk("rst_perf_stall", perf_stall_cycles, 0);
`endif
        @(negedge clk);
        poison = 1'b1;
        @(negedge clk);
        poison = 1'b0;
        reset_n = 1'b1;
        for (int c = 1; c <= ML; c++) begin
            #1;
            chk_reset_outputs("flush");
            @(negedge clk);
        end
        #1;
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_en_c", en_c, 0);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        for (int j = 0; j < ML; j++) chk("flush_reg_c", reg_c[j], 0);
    endtask

    typedef struct {
        bit lc;
        int k;
        int md;
        int lat;
        int stall;
    } vec_t;

    initial begin
        vec_t tbl [6];
        int l;
`ifdef OPACC_CTRL_PERF_EN
        logic [31:0] pb, ps;
`endif
        tbl = '{
            '{1'b1, 3, 0, 8, 0},
            '{1'b0, 0, 0, 3, 0},
            '{1'b1, 0, 0, 5, 0},
            '{1'b0, 5, 0, 8, 0},
            '{1'b0, 1, 0, 4, 0},
            '{1'b1, 3, 2, 15, 7}
        };

        do_reset();

        for (int i = 0; i < 6; i++) begin
`ifdef OPACC_CTRL_PERF_EN
            pb = perf_busy_cycles;
            ps = perf_stall_cycles;
`endif
            run_tiles(1, tbl[i].lc, tbl[i].k, 1'b0, 0, tbl[i].md, 0, l);
            chk("tile_latency", l, tbl[i].lat);
`ifdef OPACC_CTRL_PERF_EN
            chk("perf_busy_delta", perf_busy_cycles - pb, tbl[i].lat - 1);
            chk("perf_stall_delta", perf_stall_cycles - ps, tbl[i].stall);
`endif
        end

        for (int i = 0; i < 20; i++) begin
            bit rl;
            int rk;
            rl = 1'($urandom_range(0, 1));
            rk = $urandom_range(0, 12);
            run_tiles(1, rl, rk, 1'b0, 0, 1, 0, l);
            chk("rand_latency_min", l >= 1 + ML * int'(rl) + rk + ML, 1);
        end

        run_tiles(2, 1'b1, 2, 1'b0, 1, 0, 0, l);
        chk("b2b_fire_with_done", fire_with_done, 1);
        chk("b2b_second_latency", l, 4);

        run_tiles(1, 1'b0, 3, 1'b0, 0, 0, 1, l);
        do_reset();
        run_tiles(1, 1'b0, 0, 1'b0, 0, 0, 0, l);
        chk("post_reset_latency", l, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
